// File: rtl/idct_transpose4.sv
// Ping-pong 4x4 transpose buffer between the row and column IDCT passes.
// Raster-order words in; one column per cycle out, lane k skewed by k-1 cycles.
module idct_transpose4 #(
  parameter int unsigned DW = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic signed [DW-1:0] out_col_1,
  output logic signed [DW-1:0] out_col_2,
  output logic signed [DW-1:0] out_col_3,
  output logic signed [DW-1:0] out_col_4
);

  localparam int unsigned IDXW = 4;
  localparam int unsigned COLW = 2;

  typedef enum logic {IDLE, READ} state_t;

  state_t            state_q;
  logic [1:0]        full_q;
  logic              wr_bank_q;
  logic [IDXW-1:0]   wr_idx_q;
  logic              rd_bank_q;
  logic [COLW-1:0]   col_q;

  logic signed [DW-1:0] mem_q [2][4][4];
  logic signed [DW-1:0] rd_col [4];

  // Skew chains: stage 0 loads alongside out_col_1, the last stage is the lane output.
  logic signed [DW-1:0] lane2_q;
  logic signed [DW-1:0] lane3_q [2];
  logic signed [DW-1:0] lane4_q [3];

  logic accept;
  logic load;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = in_valid && in_ready && !clear;
  // A filled read bank is loaded on the very edge it is seen full, so IDLE adds no bubble.
  assign load     = !clear && ((state_q == READ) || full_q[rd_bank_q]);

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rd_col[r] = mem_q[rd_bank_q][2'(r)][col_q];
    end
  end

  // Storage has no reset; contents are only read once a bank is flagged full.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_idx_q[3:2]][wr_idx_q[1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      col_q      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_col_1  <= '0;
      out_col_2  <= '0;
      out_col_3  <= '0;
      out_col_4  <= '0;
      lane2_q    <= '0;
      lane3_q[0] <= '0;
      lane3_q[1] <= '0;
      lane4_q[0] <= '0;
      lane4_q[1] <= '0;
      lane4_q[2] <= '0;
    end else begin
      out_valid  <= load;
      out_last   <= load && (col_q == COLW'(3));
      out_col_1  <= load ? rd_col[0] : '0;

      lane2_q    <= load ? rd_col[1] : '0;
      out_col_2  <= lane2_q;
      lane3_q[0] <= load ? rd_col[2] : '0;
      lane3_q[1] <= lane3_q[0];
      out_col_3  <= lane3_q[1];
      lane4_q[0] <= load ? rd_col[3] : '0;
      lane4_q[1] <= lane4_q[0];
      lane4_q[2] <= lane4_q[1];
      out_col_4  <= lane4_q[2];

      if (clear) begin
        state_q   <= IDLE;
        full_q    <= 2'b00;
        wr_bank_q <= 1'b0;
        wr_idx_q  <= '0;
        rd_bank_q <= 1'b0;
        col_q     <= '0;
      end else begin
        if (accept) begin
          wr_idx_q <= wr_idx_q + IDXW'(1);
          if (wr_idx_q == IDXW'(15)) begin
            full_q[wr_bank_q] <= 1'b1;
            wr_bank_q         <= ~wr_bank_q;
          end
        end
        // Write and read never target the same bank, so both flag updates may land together.
        if (load) begin
          if (col_q == COLW'(3)) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
            col_q             <= '0;
            state_q           <= full_q[~rd_bank_q] ? READ : IDLE;
          end else begin
            col_q   <= col_q + COLW'(1);
            state_q <= READ;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_transpose4.sv
// Self-checking bench for idct_transpose4: directed tables plus random traffic
// checked against a block-queue model with per-lane delay history.
module tb_idct_transpose4;

  localparam int unsigned DW = 25;

  logic                 clk;
  logic                 reset;
  logic                 clear;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic signed [DW-1:0] out_col_1;
  logic signed [DW-1:0] out_col_2;
  logic signed [DW-1:0] out_col_3;
  logic signed [DW-1:0] out_col_4;

  idct_transpose4 #(.DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_col_1(out_col_1),
    .out_col_2(out_col_2),
    .out_col_3(out_col_3),
    .out_col_4(out_col_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef logic signed [15:0][DW-1:0] blk_t;
  typedef logic signed [3:0][DW-1:0]  col_t;

  // Model: completed blocks awaiting read-out, partial block, read column, load history.
  blk_t  blocks[$];
  blk_t  partial;
  int    pcount;
  int    rdcol;
  col_t  hist[$];
  logic  exp_valid;
  logic  exp_last;

  typedef struct {
    logic                 v;
    logic                 l;
    logic signed [DW-1:0] c1;
    logic signed [DW-1:0] c2;
    logic signed [DW-1:0] c3;
    logic signed [DW-1:0] c4;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, $signed(act), $signed(exp));
    end
  endtask

  task automatic model_reset();
    blocks.delete();
    partial = '0;
    pcount = 0;
    rdcol = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(col_t'(0));
    exp_valid = 1'b0;
    exp_last = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic signed [DW-1:0] d, input logic clr);
    col_t ld;
    logic ld_v;
    logic ld_last;
    logic acc;
    ld = '0;
    ld_v = 1'b0;
    ld_last = 1'b0;
    acc = v && (blocks.size() < 2) && !clr;
    if (clr) begin
      blocks.delete();
      pcount = 0;
      rdcol = 0;
    end else begin
      if (blocks.size() > 0) begin
        for (int r = 0; r < 4; r++) ld[r] = blocks[0][r*4 + rdcol];
        ld_v = 1'b1;
        ld_last = (rdcol == 3);
        rdcol++;
        if (rdcol == 4) begin
          rdcol = 0;
          void'(blocks.pop_front());
        end
      end
      if (acc) begin
        partial[pcount] = d;
        pcount++;
        if (pcount == 16) begin
          blocks.push_back(partial);
          pcount = 0;
        end
      end
    end
    hist.push_front(ld);
    void'(hist.pop_back());
    exp_valid = ld_v;
    exp_last = ld_last;
  endtask

  task automatic compare_all();
    chk("in_ready",  DW'(in_ready),  DW'(blocks.size() < 2));
    chk("out_valid", DW'(out_valid), DW'(exp_valid));
    chk("out_last",  DW'(out_last),  DW'(exp_last));
    chk("out_col_1", out_col_1, hist[0][0]);
    chk("out_col_2", out_col_2, hist[1][1]);
    chk("out_col_3", out_col_3, hist[2][2]);
    chk("out_col_4", out_col_4, hist[3][3]);
  endtask

  task automatic step(input logic v, input logic signed [DW-1:0] d, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    clear = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    compare_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, DW'(out_valid), '0);
    chk({tag, "_last"},  DW'(out_last),  '0);
    chk({tag, "_c1"}, out_col_1, '0);
    chk({tag, "_c2"}, out_col_2, '0);
    chk({tag, "_c3"}, out_col_3, '0);
    chk({tag, "_c4"}, out_col_4, '0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, "_in_ready"}, DW'(in_ready), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] w;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // Block 1..16 then hand-derived transposed, skewed output table.
    tbl[0] = '{1'b1, 1'b0, 1, 0,  0,  0};
    tbl[1] = '{1'b1, 1'b0, 2, 5,  0,  0};
    tbl[2] = '{1'b1, 1'b0, 3, 6,  9,  0};
    tbl[3] = '{1'b1, 1'b1, 4, 7, 10, 13};
    tbl[4] = '{1'b0, 1'b0, 0, 8, 11, 14};
    tbl[5] = '{1'b0, 1'b0, 0, 0, 12, 15};
    tbl[6] = '{1'b0, 1'b0, 0, 0,  0, 16};
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    for (int n = 0; n < 7; n++) begin
      step(1'b0, '0, 1'b0);
      chk("tbl_valid", DW'(out_valid), DW'(tbl[n].v));
      chk("tbl_last",  DW'(out_last),  DW'(tbl[n].l));
      chk("tbl_c1", out_col_1, tbl[n].c1);
      chk("tbl_c2", out_col_2, tbl[n].c2);
      chk("tbl_c3", out_col_3, tbl[n].c3);
      chk("tbl_c4", out_col_4, tbl[n].c4);
    end

    // Signed extremes, alternating.
    for (int i = 0; i < 16; i++) begin
      w = (i % 2 == 0) ? -DW'(16777216) : DW'(16777215);
      step(1'b1, w, 1'b0);
    end
    repeat (8) step(1'b0, '0, 1'b0);

    // Three back-to-back blocks with continuous valid.
    for (int i = 1; i <= 48; i++) begin
      step(1'b1, DW'(i), 1'b0);
      chk("stream_ready", DW'(in_ready), DW'(1));
    end
    repeat (8) step(1'b0, '0, 1'b0);

    // Clear after 7 words, then a clean block 100..115.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(50 + i), 1'b0);
    step(1'b1, DW'(57), 1'b1);
    chk("clr_valid", DW'(out_valid), '0);
    for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0);
      chk("clr_c1", out_col_1, DW'(100 + i));
    end
    repeat (4) step(1'b0, '0, 1'b0);

    // Reset in the middle of a read-out, then a fresh block.
    for (int i = 0; i < 16; i++) step(1'b1, DW'(200 + i), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    do_reset("rst_mid");
    for (int i = 0; i < 16; i++) step(1'b1, DW'(300 + i), 1'b0);
    repeat (8) step(1'b0, '0, 1'b0);

    // Random traffic with occasional clear.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 63) == 0));
    end
    repeat (8) step(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_transpose4.md
Name: idct_transpose4

Overview:
- Ping-pong 4x4 transpose buffer between the first (row) and second (column) 4-point IDCT passes.
- Accepts the serial 25-bit row-pass results in raster order.
- Emits one column per cycle on four lanes. Lane k is skewed by k-1 cycles, so the lanes can drive the d_in_1..d_in_4 inputs of the systolic 4-point IDCT column stage directly.

Parameters:
- DW, 25, data word width (signed two's complement); all lanes and storage use DW.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- clear  input  1  synchronous flush; empties both banks and aborts any read-out
- in_valid  input  1  in_data is presented
- in_data  input  DW  signed row-pass result, raster order (row 0 col 0, row 0 col 1, ...)
- in_ready  output  1  buffer can accept in_data this cycle
- out_valid  output  1  out_col_1 carries a valid column element
- out_last  output  1  out_col_1 carries column 3 (last of the block)
- out_col_1  output  DW  element row 0 of the current column, no skew
- out_col_2  output  DW  element row 1, delayed 1 cycle relative to out_col_1
- out_col_3  output  DW  element row 2, delayed 2 cycles
- out_col_4  output  DW  element row 3, delayed 3 cycles

Behaviour:
- Reset (reset=0, async):
  - All outputs, skew registers, pointers and bank-full flags go to 0.
  - in_ready therefore reads 1 once reset is released.
  - Storage contents are don't-care.
- Storage: two banks of 16 x DW words, bank0 and bank1, each with a full flag.
- Write side:
  - wr_bank and wr_idx (0..15) select the location.
  - A word is accepted on a rising edge with in_valid=1 and in_ready=1.
  - Accepted word is stored at mem[wr_bank][wr_idx>>2][wr_idx&3]; wr_idx increments.
  - On accepting wr_idx=15: set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
  - in_ready = !full[wr_bank] (combinational from registered state).
- Read side: FSM with states IDLE and READ, plus rd_bank and col counter c (0..3).
  - IDLE -> READ when full[rd_bank]=1; c=0.
  - In READ, each edge loads column c: out_col_1 <= mem[rd_bank][0][c]; stage-0 registers of lanes 2..4 <= rows 1..3 of column c.
  - Same edge sets out_valid<=1, and out_last<=1 when c=3.
  - After c=3: clear full[rd_bank], toggle rd_bank, then:
    - if the other bank is already full, stay in READ with c=0 (back-to-back columns, no bubble);
    - otherwise go to IDLE.
  - When not loading, out_valid<=0, out_last<=0, out_col_1<=0.
- Skew: lane k (k=2..4) is a k-1 deep register chain.
  - The chain shifts every cycle, including zeros when no column is loaded.
  - out_col_k therefore shows column c k-1 cycles after out_col_1 does.
- Latency:
  - Word 15 accepted at edge E.
  - Column 0 appears on out_col_1 after edge E+1; on out_col_4 after edge E+4.
  - The full block has left out_col_4 after edge E+7.
- Throughput: 16 input cycles per block against 4 read cycles, so with ping-pong a continuous in_valid stream never sees in_ready=0.
- Simultaneous events:
  - If a read completes freeing bank X on the same edge that write fills bank Y, both updates apply.
  - A write to the freed bank may begin on the next edge.
- Backpressure: both banks full gives in_ready=0; words offered are not accepted and wr_idx holds.
- clear=1 on an edge:
  - Full flags, wr_idx, wr_bank, rd_bank and c go to 0; FSM goes to IDLE.
  - out_valid and out_last are 0 after that edge.
  - Skew chains keep draining and are not zeroed.
  - clear takes priority over a simultaneous accept.
- Reset mid-block: all partial state is lost; the next block starts at wr_idx=0, bank0.
- Data is stored and forwarded bit-exact: no rounding, saturation or sign change.

Test Plan:
- Reset then block values 1..16 at full rate -> out_col_1 reads 1,2,3,4 on consecutive cycles starting one cycle after word 16 is accepted. out_col_2 reads 5,6,7,8 one cycle later; out_col_3 reads 9..12 two cycles later; out_col_4 reads 13..16 three cycles later. out_last=1 only with out_col_1=4.
- Signed extremes: block of alternating -16777216 and 16777215 -> identical values at the transposed positions, sign preserved on all four lanes.
- Three back-to-back blocks (1..16, 17..32, 33..48) with continuous in_valid -> in_ready never 0. Each block's columns appear with no corruption between blocks; second block's column 0 on out_col_1 is 17,18,19,20 ordering per lane as in scenario 1.
- Force both banks full by sending 32 words with reads stalled (hold reset pattern: send block 2 during block 1 read) -> in_ready=0 exactly while both full flags are set. The word held on in_data is accepted on the first edge after a bank frees.
- clear asserted after 7 words of a block -> out_valid stays 0. The next 16 words (100..115) produce out_col_1 = 100,101,102,103 with no leftover data.
- Assert reset=0 mid-read (after column 1) -> all outputs read 0 immediately. After release, in_ready=1 and a fresh block transposes correctly.
